jac1_regval_uart_tx: RTL and testbench

//   Downstream consumer of the JAC1 core's reg_val output. Detects every change of reg_val
//   and queues the new value in a small FIFO. Sends queued values as 8N1 UART frames on a

---
 rtl/jac1_regval_uart_tx_if.sv | 18 +
 rtl/jac1_regval_uart_tx.sv | 104 ++++++++++
 tb/tb_jac1_regval_uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jac1_regval_uart_tx_if.sv
// jac1_regval_uart_tx_if: reg_val in, UART tx and status out.
//   reg_val     register value from JAC1_Top (master drives)
//   tx          UART serial line, idle high
//   busy        frame in progress
//   fifo_count  queued, unsent values
//   overflow    sticky value-dropped flag
interface jac1_regval_uart_tx_if #(
  parameter int DataWidth = 8,
  parameter int FifoDepth = 4
);
  logic [DataWidth-1:0]         reg_val;
  logic                         tx;
  logic                         busy;
  logic [$clog2(FifoDepth):0]   fifo_count;
  logic                         overflow;
  modport master (output reg_val, input tx, busy, fifo_count, overflow);
  modport slave (input reg_val, output tx, busy, fifo_count, overflow);
endinterface

// File: rtl/jac1_regval_uart_tx.sv
// jac1_regval_uart_tx: queues every change of reg_val and sends it as an 8N1 UART frame.
//   clk      system clock, rising edge
//   sys_res  synchronous active-high reset
//   bus      slave side: reg_val in; tx, busy, fifo_count, overflow out
module jac1_regval_uart_tx #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 16,
  parameter int FifoDepth  = 4
) (
  input logic                  clk,
  input logic                  sys_res,
  jac1_regval_uart_tx_if.slave bus
);
  localparam int PW = $clog2(FifoDepth);
  localparam int BW = $clog2(ClksPerBit);
  localparam int NW = $clog2(DataWidth);
  localparam logic [BW-1:0] BAUD_MAX = BW'(ClksPerBit - 1);
  localparam logic [NW-1:0] BIT_MAX = NW'(DataWidth - 1);
  localparam logic [PW:0] FULL = (PW+1)'(FifoDepth);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               r_state, w_state;
  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [DataWidth-1:0] r_prev, r_shift, w_shift;
  logic                 r_prev_valid, r_tx, w_tx, r_overflow;
  logic                 w_push, w_pop, w_acc, w_bit_end;
  logic [PW-1:0]        r_wr, r_rd;
  logic [PW:0]          r_count;
  logic [BW-1:0]        r_baud, w_baud;
  logic [NW-1:0]        r_bit, w_bit;
  assign w_push    = !r_prev_valid || bus.reg_val != r_prev;
  // a full FIFO still accepts when the head leaves on the same edge
  assign w_acc     = w_push && (r_count != FULL || w_pop);
  assign w_bit_end = r_baud == BAUD_MAX;
  assign bus.tx         = r_tx;
  assign bus.busy       = r_state != IDLE;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
  // w_tx is the line level for the cycle after this edge, so tx stays a flop output
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_baud  = r_baud + 1'b1;
    w_bit   = r_bit;
    w_tx    = r_tx;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: if (r_count != '0) begin
        w_pop   = 1'b1;
        w_shift = r_mem[r_rd];
        w_baud  = '0;
        w_state = START;
        w_tx    = 1'b0;
      end
      START: if (w_bit_end) begin
        w_state = DATA;
        w_bit   = '0;
        w_baud  = '0;
        w_tx    = r_shift[0];
      end
      DATA: if (w_bit_end) begin
        w_baud  = '0;
        w_state = r_bit == BIT_MAX ? STOP : DATA;
        w_bit   = r_bit + 1'b1;
        w_shift = r_shift >> 1;
        w_tx    = r_bit == BIT_MAX ? 1'b1 : r_shift[1];
      end
      STOP: if (w_bit_end) begin
        w_state = IDLE;
        w_baud  = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (sys_res) begin
      r_state      <= IDLE;
      r_tx         <= 1'b1;
      r_shift      <= '0;
      r_baud       <= '0;
      r_bit        <= '0;
      r_count      <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_overflow   <= 1'b0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_tx         <= w_tx;
      r_shift      <= w_shift;
      r_baud       <= w_baud;
      r_bit        <= w_bit;
      r_count      <= r_count + (PW+1)'(w_acc) - (PW+1)'(w_pop);
      r_wr         <= r_wr + PW'(w_acc);
      r_rd         <= r_rd + PW'(w_pop);
      r_overflow   <= r_overflow | (w_push & !w_acc);
      r_prev       <= bus.reg_val;
      r_prev_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!sys_res && w_acc) r_mem[r_wr] <= bus.reg_val;
  end
endmodule

// File: tb/tb_jac1_regval_uart_tx.sv
// tb_jac1_regval_uart_tx: random reg_val activity against a frame-timing reference model and a UART receiver.
module tb_jac1_regval_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;
  logic clk = 1'b0;
  logic sys_res = 1'b1;
  int checks = 0;
  int failures = 0;
  jac1_regval_uart_tx_if #(.DataWidth(8), .FifoDepth(D)) bus ();
  jac1_regval_uart_tx #(.DataWidth(8), .ClksPerBit(C), .FifoDepth(D)) dut (
    .clk(clk), .sys_res(sys_res), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference model: queue of waiting values, one frame of FRAME cycles per pop,
  // next pop possible one cycle after the previous frame ends
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_prev, m_val;
  bit m_prev_valid = 0, m_active = 0, m_ovf = 0, started = 0;
  int cyc = 0, m_pop = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (sys_res) begin
      mq.delete();
      exp_q.delete();
      m_prev_valid = 0;
      m_active = 0;
      m_ovf = 0;
      started = 1;
    end else begin
      bit pop;
      pop = mq.size() != 0 && (!m_active || cyc > m_pop + FRAME);
      if (pop) begin
        m_val = mq.pop_front();
        exp_q.push_back(m_val);
        m_pop = cyc;
        m_active = 1;
      end
      if (!m_prev_valid || bus.reg_val != m_prev) begin
        if (mq.size() < D) mq.push_back(bus.reg_val);
        else m_ovf = 1;
      end
      m_prev = bus.reg_val;
      m_prev_valid = 1;
    end
  end

  int peak = 0;
  initial forever begin
    @(negedge clk);
    if (started) begin
      int d;
      bit mb, mt;
      d = cyc - m_pop;
      mb = m_active && d < FRAME;
      mt = !mb ? 1'b1 : d < C ? 1'b0 : d < 9 * C ? m_val[(d - C) / C] : 1'b1;
      chk("busy", bus.busy, mb);
      chk("tx", bus.tx, mt);
      chk("fifo_count", bus.fifo_count, mq.size());
      chk("overflow", bus.overflow, m_ovf);
      if (bus.fifo_count > peak) peak = bus.fifo_count;
    end
  end

  // UART receiver sampling mid-bit, decoupled from the model
  bit rx_on = 0;
  int j = 0;
  logic [7:0] rx;
  initial forever begin
    @(negedge clk);
    if (sys_res) rx_on = 0;
    else if (!rx_on) begin
      if (bus.tx === 1'b0) begin
        rx_on = 1;
        j = 0;
      end
    end else j++;
    if (rx_on) begin
      if (j == C / 2) chk("start_bit", bus.tx, 0);
      for (int i = 1; i <= 8; i++) if (j == i * C + C / 2) rx[i-1] = bus.tx;
      if (j == 9 * C + C / 2) begin
        chk("stop_bit", bus.tx, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected actual=%0h expected=none at %0t", rx, $time);
        end else chk("frame", rx, exp_q.pop_front());
        rx_on = 0;
      end
    end
  end

  initial begin
    logic [7:0] v;
    bus.reg_val = 8'h00;
    sys_res = 1'b1;
    tick(3);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ovf", bus.overflow, 0);
    sys_res = 1'b0;
    tick(FRAME + 20);
    bus.reg_val = 8'hA5;
    tick(FRAME + 20);
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      bus.reg_val = 8'(8'h11 * (i + 1));
      tick(1);
    end
    chk("burst_ovf", bus.overflow, 1);
    chk("burst_peak", peak, 4);
    tick(6 * (FRAME + 1) + 200);
    chk("stable_busy", bus.busy, 0);
    chk("stable_count", bus.fifo_count, 0);
    bus.reg_val = 8'h3C;
    tick(2 + 4 * C);
    sys_res = 1'b1;
    tick(1);
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_count", bus.fifo_count, 0);
    sys_res = 1'b0;
    tick(1);
    chk("rel_push", bus.fifo_count, 1);
    tick(FRAME + 10);
    v = 8'h3C;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) v = 8'($urandom_range(0, 255));
      bus.reg_val = v;
      tick($urandom_range(0, 2) == 0 ? 1 : $urandom_range(1, 60));
    end
    tick(D * (FRAME + 1) + 50);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_rx", rx_on, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
